// File: rtl/button_conditioner.sv
// Synchronizes and debounces the left/right/missile buttons in the pclk domain.
// The missile press also produces a one-cycle fire pulse, rate-limited by a frame-counted cooldown.
module button_conditioner #(
    parameter int DEB_CYCLES      = 650000,
    parameter int CNT_W           = 20,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int CD_W            = 4
) (
    input  logic pclk,
    input  logic rst,
    input  logic left_in,
    input  logic right_in,
    input  logic missile_in,
    input  logic vsync_in,
    output logic left_out,
    output logic right_out,
    output logic missile_held,
    output logic missile_out
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CNT = 2'd1,
        HELD      = 2'd2,
        REL_CNT   = 2'd3
    } deb_state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CD_W-1:0]  CD_LOAD  = CD_W'(COOLDOWN_FRAMES);
    localparam logic [CD_W-1:0]  CD_ZERO  = {CD_W{1'b0}};
    localparam logic [CD_W-1:0]  CD_ONE   = {{(CD_W-1){1'b0}}, 1'b1};

    // Button index 0 = left, 1 = right, 2 = missile.
    logic [2:0]       pin_s;
    logic [2:0]       sync1_q, sync1_d;
    logic [2:0]       sync2_q, sync2_d;
    logic [2:0]       level_q, level_d;
    logic [2:0]       enter_held_s;
    deb_state_e       state_q [3];
    deb_state_e       state_d [3];
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    logic [CD_W-1:0]  cd_q, cd_d;
    logic             vsync_q, vsync_d;
    logic             missile_out_q, missile_out_d;
    logic             vsync_rise_s;
    logic             fire_s;

    assign pin_s = {missile_in, right_in, left_in};

    // Synchronizer chain and per-button debounce FSMs.
    always_comb begin
        sync1_d      = pin_s;
        sync2_d      = sync1_q;
        level_d      = level_q;
        enter_held_s = 3'b000;
        for (int b = 0; b < 3; b++) begin
            state_d[b] = state_q[b];
            cnt_d[b]   = cnt_q[b];
            case (state_q[b])
                IDLE: begin
                    level_d[b] = 1'b0;
                    if (sync2_q[b]) begin
                        state_d[b] = PRESS_CNT;
                        cnt_d[b]   = CNT_ZERO;
                    end else begin
                        state_d[b] = IDLE;
                    end
                end
                PRESS_CNT: begin
                    if (!sync2_q[b]) begin
                        state_d[b] = IDLE;
                        cnt_d[b]   = CNT_ZERO;
                    end else if (cnt_q[b] == CNT_LAST) begin
                        state_d[b]      = HELD;
                        cnt_d[b]        = CNT_ZERO;
                        level_d[b]      = 1'b1;
                        enter_held_s[b] = 1'b1;
                    end else begin
                        cnt_d[b] = cnt_q[b] + CNT_ONE;
                    end
                end
                HELD: begin
                    level_d[b] = 1'b1;
                    if (!sync2_q[b]) begin
                        state_d[b] = REL_CNT;
                        cnt_d[b]   = CNT_ZERO;
                    end else begin
                        state_d[b] = HELD;
                    end
                end
                REL_CNT: begin
                    if (sync2_q[b]) begin
                        state_d[b] = HELD;
                        cnt_d[b]   = CNT_ZERO;
                    end else if (cnt_q[b] == CNT_LAST) begin
                        state_d[b] = IDLE;
                        cnt_d[b]   = CNT_ZERO;
                        level_d[b] = 1'b0;
                    end else begin
                        cnt_d[b] = cnt_q[b] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[b] = IDLE;
                    cnt_d[b]   = CNT_ZERO;
                    level_d[b] = 1'b0;
                end
            endcase
        end
    end

    // Fire decision uses the pre-decrement cooldown; a load beats a vsync decrement.
    always_comb begin
        vsync_d       = vsync_in;
        vsync_rise_s  = vsync_in & ~vsync_q;
        fire_s        = enter_held_s[2] & (cd_q == CD_ZERO);
        missile_out_d = fire_s;
        if (fire_s) begin
            cd_d = CD_LOAD;
        end else if (vsync_rise_s && (cd_q != CD_ZERO)) begin
            cd_d = cd_q - CD_ONE;
        end else begin
            cd_d = cd_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge pclk) begin
        if (!rst) begin
            sync1_q       <= 3'b000;
            sync2_q       <= 3'b000;
            level_q       <= 3'b000;
            cd_q          <= CD_ZERO;
            vsync_q       <= 1'b0;
            missile_out_q <= 1'b0;
            for (int b = 0; b < 3; b++) begin
                state_q[b] <= IDLE;
                cnt_q[b]   <= CNT_ZERO;
            end
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            level_q       <= level_d;
            cd_q          <= cd_d;
            vsync_q       <= vsync_d;
            missile_out_q <= missile_out_d;
            for (int b = 0; b < 3; b++) begin
                state_q[b] <= state_d[b];
                cnt_q[b]   <= cnt_d[b];
            end
        end
    end

    assign left_out     = level_q[0];
    assign right_out    = level_q[1];
    assign missile_held = level_q[2];
    assign missile_out  = missile_out_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed vector table, hand-written corner sequences,
// and randomized stimulus checked every cycle against a run-length reference model.
module tb_button_conditioner;

    localparam int DEB = 4;
    localparam int CDF = 2;

    logic pclk;
    logic rst;
    logic left_in, right_in, missile_in, vsync_in;
    logic left_out, right_out, missile_held, missile_out;

    int n_checks;
    int n_fail;

    button_conditioner #(
        .DEB_CYCLES     (DEB),
        .CNT_W          (3),
        .COOLDOWN_FRAMES(CDF),
        .CD_W           (2)
    ) dut (
        .pclk        (pclk),
        .rst         (rst),
        .left_in     (left_in),
        .right_in    (right_in),
        .missile_in  (missile_in),
        .vsync_in    (vsync_in),
        .left_out    (left_out),
        .right_out   (right_out),
        .missile_held(missile_held),
        .missile_out (missile_out)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Reference model: a level flips once the synchronized pin has disagreed with it
    // for DEB+1 consecutive samples; the pin reaches the debouncer two edges late.
    bit m_pipe1 [3];
    bit m_pipe2 [3];
    bit m_level [3];
    int m_run   [3];
    int m_cd;
    bit m_vprev;
    bit m_fire;

    task automatic model_step();
        bit pins [3];
        bit seen [3];
        bit rise [3];
        bit vrise;
        pins[0] = left_in;
        pins[1] = right_in;
        pins[2] = missile_in;
        if (!rst) begin
            for (int b = 0; b < 3; b++) begin
                m_pipe1[b] = 1'b0;
                m_pipe2[b] = 1'b0;
                m_level[b] = 1'b0;
                m_run[b]   = 0;
            end
            m_cd    = 0;
            m_vprev = 1'b0;
            m_fire  = 1'b0;
        end else begin
            for (int b = 0; b < 3; b++) begin
                seen[b]    = m_pipe2[b];
                m_pipe2[b] = m_pipe1[b];
                m_pipe1[b] = pins[b];
                rise[b]    = 1'b0;
                if (seen[b] != m_level[b]) m_run[b] = m_run[b] + 1;
                else m_run[b] = 0;
                if (m_run[b] == DEB + 1) begin
                    m_level[b] = ~m_level[b];
                    m_run[b]   = 0;
                    rise[b]    = m_level[b];
                end
            end
            vrise   = vsync_in && !m_vprev;
            m_vprev = vsync_in;
            m_fire  = rise[2] && (m_cd == 0);
            if (m_fire) m_cd = CDF;
            else if (vrise && m_cd > 0) m_cd = m_cd - 1;
        end
    endtask

    task automatic check(input string name, input logic [3:0] exp);
        logic [3:0] act;
        act = {left_out, right_out, missile_held, missile_out};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {left,right,held,fire}=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        model_step();
        #1;
        check("model", {m_level[0], m_level[1], m_level[2], m_fire});
    endtask

    typedef struct {
        bit         l;
        bit         r;
        bit         m;
        bit         v;
        bit         rst_v;
        int         n;
        bit         all;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs [$];
    bit   rnd_pin [3];
    int   dur [3];

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b0;
        left_in    = 1'b0;
        right_in   = 1'b0;
        missile_in = 1'b0;
        vsync_in   = 1'b0;

        // {left, right, missile, vsync, rst, edges, check every edge, expected {l,r,held,fire}}
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  3, 1'b1, 4'b0000}); // reset
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1,  6, 1'b1, 4'b0000}); // left debouncing
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1,  1, 1'b0, 4'b1000}); // edge 7 rise
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1,  3, 1'b1, 4'b1000});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  6, 1'b1, 4'b1000}); // release debouncing
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  1, 1'b0, 4'b0000}); // edge 7 fall
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1,  6, 1'b1, 4'b0000}); // left+right together
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1,  1, 1'b0, 4'b1100});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  6, 1'b1, 4'b1100});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  2, 1'b1, 4'b0000});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b1,  3, 1'b1, 4'b0000}); // glitch
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10, 1'b1, 4'b0000});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b1,  6, 1'b1, 4'b0000}); // first fire
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b1,  1, 1'b0, 4'b0011});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b1,  3, 1'b1, 4'b0010}); // no auto-fire
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  6, 1'b1, 4'b0010});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  2, 1'b1, 4'b0000});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b1,  6, 1'b1, 4'b0000}); // re-press in cooldown
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b1,  3, 1'b1, 4'b0010});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  8, 1'b0, 4'b0000});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1,  1, 1'b1, 4'b0000}); // two vsync rises
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  1, 1'b1, 4'b0000});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1,  1, 1'b1, 4'b0000});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  1, 1'b1, 4'b0000});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b1,  6, 1'b1, 4'b0000}); // fires again
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b1,  1, 1'b0, 4'b0011});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b1,  2, 1'b1, 4'b0010});

        for (int i = 0; i < vecs.size(); i++) begin
            left_in    = vecs[i].l;
            right_in   = vecs[i].r;
            missile_in = vecs[i].m;
            vsync_in   = vecs[i].v;
            rst        = vecs[i].rst_v;
            for (int k = 0; k < vecs[i].n; k++) begin
                tick();
                if (vecs[i].all || k == vecs[i].n - 1) check($sformatf("vec%0d", i), vecs[i].exp);
            end
        end

        // Cooldown at 1 and press acceptance coinciding with a vsync rise.
        missile_in = 1'b0;
        repeat (8) tick();
        check("t4_released", 4'b0000);
        vsync_in = 1'b1;
        tick();
        vsync_in = 1'b0;
        tick();
        missile_in = 1'b1;
        repeat (6) tick();
        vsync_in = 1'b1;
        tick();
        check("t4_coincide_no_pulse", 4'b0010);
        vsync_in   = 1'b0;
        missile_in = 1'b0;
        repeat (8) tick();
        check("t4_released2", 4'b0000);
        missile_in = 1'b1;
        repeat (7) tick();
        check("t4_repress_pulse", 4'b0011);
        tick();
        check("t4_pulse_one_cycle", 4'b0010);

        // Reset while missile is held with cooldown loaded; button stays held through release.
        rst = 1'b0;
        tick();
        check("t5_reset_outputs", 4'b0000);
        tick();
        rst = 1'b1;
        repeat (6) tick();
        check("t5_before_fire", 4'b0000);
        tick();
        check("t5_fire_after_reset", 4'b0011);

        // Randomized pins, vsync and occasional reset against the model.
        for (int b = 0; b < 3; b++) begin
            rnd_pin[b] = 1'b0;
            dur[b]     = $urandom_range(1, 9);
        end
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (dur[b] == 0) begin
                    rnd_pin[b] = ~rnd_pin[b];
                    dur[b]     = $urandom_range(1, 9);
                end else begin
                    dur[b] = dur[b] - 1;
                end
            end
            left_in    = rnd_pin[0];
            right_in   = rnd_pin[1];
            missile_in = rnd_pin[2];
            if ($urandom_range(0, 2) == 0) vsync_in = ~vsync_in;
            rst = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
